regex_line_feeder: RTL and testbench

Upstream front-end for the `regex` matcher. It accepts one `WIDTH`-bit input line per valid/ready handshake and shifts it MSB-first, one bit per clock, onto the matcher's serial character input. It then waits a fixed settle window, samples the matcher's match output and returns a per-line result tagged with a 1-based line number. It replaces testbench-driven serialisation so that lines can be streamed from a memory or FIFO in hardware.

---
 rtl/regex_pkg.sv | 14 +
 rtl/regex_piso.sv | 46 ++++
 rtl/regex_line_feeder.sv | 112 +++++++++++
 tb/tb_regex_line_feeder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regex_pkg.sv
// Shared definitions for the regex matcher front-end and its line feeder.
package regex_pkg;

  localparam int unsigned REGEX_WIDTH  = 21;
  localparam int unsigned REGEX_LINE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SETTLE,
    ST_REPORT
  } feeder_state_t;

endpackage

// File: rtl/regex_piso.sv
// Parallel-in/serial-out shifter: MSB-first registered serial bit, with a
// done flag raised while the final bit is on the output.
module regex_piso
  import regex_pkg::*;
#(
  parameter int unsigned WIDTH = REGEX_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ser_o,
  output logic             done_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             ser_q;

  // The MSB goes straight into the output register on load, so sr_q holds
  // only the bits still to come; the serial output drops to 0 after the last bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ser_q <= 1'b0;
    end else if (load_i) begin
      ser_q <= data_i[WIDTH-1];
      sr_q  <= data_i << 1;
      cnt_q <= CW'(WIDTH - 1);
    end else if (shift_i) begin
      ser_q <= (cnt_q == '0) ? 1'b0 : sr_q[WIDTH-1];
      sr_q  <= sr_q << 1;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign ser_o  = ser_q;
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/regex_line_feeder.sv
// Serialises one input line per handshake onto the regex matcher, waits a
// settle window, samples the match output and returns a numbered result.
module regex_line_feeder
  import regex_pkg::*;
#(
  parameter int unsigned WIDTH  = REGEX_WIDTH,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned LINE_W = REGEX_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              re_i,
  output logic              re_ic,
  input  logic              re_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_match,
  output logic [LINE_W-1:0] res_line,
  output logic [LINE_W-1:0] match_count,
  output logic              busy
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  feeder_state_t     state_q;
  logic [SW-1:0]     settle_q;
  logic [LINE_W-1:0] line_cnt_q;
  logic [LINE_W-1:0] res_line_q;
  logic [LINE_W-1:0] match_cnt_q;
  logic              re_i_q;
  logic              res_valid_q;
  logic              res_match_q;
  logic              accept;
  logic              shift_en;
  logic              piso_done;

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign shift_en = (state_q == ST_SHIFT);

  regex_piso #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (accept),
    .shift_i(shift_en),
    .data_i (in_data),
    .ser_o  (re_ic),
    .done_o (piso_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      line_cnt_q  <= '0;
      res_line_q  <= '0;
      match_cnt_q <= '0;
      re_i_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
    end else begin
      re_i_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            line_cnt_q <= line_cnt_q + LINE_W'(1);
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (piso_done) begin
            settle_q <= SW'(SETTLE - 1);
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            res_match_q <= re_o;
            res_line_q  <= line_cnt_q;
            res_valid_q <= 1'b1;
            if (re_o && (match_cnt_q != '1)) begin
              match_cnt_q <= match_cnt_q + LINE_W'(1);
            end
            state_q <= ST_REPORT;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign re_i        = re_i_q;
  assign res_valid   = res_valid_q;
  assign res_match   = res_match_q;
  assign res_line    = res_line_q;
  assign match_count = match_cnt_q;

endmodule

// File: tb/tb_regex_line_feeder.sv
// Bench for regex_line_feeder: stub matcher pulses re_o only in the sample
// cycle; results are checked against a queue of expected {match, line}.
module tb_regex_line_feeder;

  localparam int W  = 21;
  localparam int SE = 1;
  localparam int LW = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          re_i;
  logic          re_ic;
  logic          re_o;
  logic          res_valid;
  logic          res_ready;
  logic          res_match;
  logic [LW-1:0] res_line;
  logic [LW-1:0] match_count;
  logic          busy;

  regex_line_feeder #(
    .WIDTH (W),
    .SETTLE(SE),
    .LINE_W(LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .re_i       (re_i),
    .re_ic      (re_ic),
    .re_o       (re_o),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_match  (res_match),
    .res_line   (res_line),
    .match_count(match_count),
    .busy       (busy)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         re_o;
    logic         exp_match;
  } vec_t;

  typedef struct {
    logic          match;
    logic [LW-1:0] line;
  } exp_t;

  vec_t          vecs[5];
  exp_t          sb[$];
  int            acc_times[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] line_m = '0;
  logic [LW-1:0] mc_m = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor / scoreboard pop, plus accept-time log
  always @(negedge clk) begin
    exp_t e;
    if (!reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result line %0d, expected none", res_line);
      end else begin
        e = sb.pop_front();
        chk("res_match", 32'(res_match), 32'(e.match));
        chk("res_line", 32'(res_line), 32'(e.line));
      end
    end
    if (!reset && in_valid && in_ready) acc_times.push_back(cyc);
  end

  task automatic send_line(input logic [W-1:0] d, input logic m, input logic rr,
                           input logic hold_v);
    int n;
    in_data   = d;
    in_valid  = 1'b1;
    res_ready = rr;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    tick();  // accept edge t; now in cycle t+1
    in_valid = hold_v;
    line_m   = line_m + 1'b1;
    sb.push_back('{m, line_m});
    if (m && mc_m != '1) mc_m = mc_m + 1'b1;
    in_data = W'($urandom);
    for (int k = 0; k < W; k++) begin
      chk("re_ic_bit", 32'(re_ic), 32'(d[W-1-k]));
      if (k == W / 2) begin
        chk("in_ready_shift", 32'(in_ready), 32'(0));
        chk("busy_shift", 32'(busy), 32'(1));
      end
      tick();
    end
    for (int s = 0; s < SE; s++) begin
      chk("re_ic_settle", 32'(re_ic), 32'(0));
      re_o = (s == SE - 1) ? m : 1'b0;
      tick();
    end
    re_o = 1'b0;
    chk("res_valid_rise", 32'(res_valid), 32'(1));
    chk("match_count", 32'(match_count), 32'(mc_m));
  endtask

  initial begin
    int rel_cyc;
    int idx0;
    int rv_seen;
    logic [W-1:0] d;

    vecs[0] = '{21'h100001, 1'b0, 1'b0};
    vecs[1] = '{21'h0AAAAA, 1'b1, 1'b1};
    vecs[2] = '{21'h155555, 1'b0, 1'b0};
    vecs[3] = '{21'h1FFFFF, 1'b1, 1'b1};
    vecs[4] = '{21'h0F0F0F, 1'b0, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    re_o = 1'b0;
    res_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_re_i", 32'(re_i), 32'(0));
    chk("rst_re_ic", 32'(re_ic), 32'(0));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_res_match", 32'(res_match), 32'(0));
    chk("rst_res_line", 32'(res_line), 32'(0));
    chk("rst_match_count", 32'(match_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    tick();
    chk("re_i_after_reset", 32'(re_i), 32'(1));
    chk("in_ready_after_reset", 32'(in_ready), 32'(1));

    // Table-driven lines; matches on lines 2 and 4
    for (int i = 0; i < 5; i++) begin
      send_line(vecs[i].data, vecs[i].re_o, 1'b1, 1'b0);
      sb[sb.size()-1].match = vecs[i].exp_match;
    end
    tick();
    chk("match_count_after_vectors", 32'(match_count), 32'(2));

    // Result back-pressure: hold REPORT for 10 cycles with a pending in_valid
    d = 21'h12345;
    send_line(d, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = W'($urandom);
      chk("hold_res_valid", 32'(res_valid), 32'(1));
      chk("hold_res_match", 32'(res_match), 32'(1));
      chk("hold_res_line", 32'(res_line), 32'(line_m));
      chk("hold_in_ready", 32'(in_ready), 32'(0));
      tick();
    end
    res_ready = 1'b1;
    rel_cyc = cyc;
    tick();
    send_line(21'h1C0003, 1'b0, 1'b1, 1'b0);
    chk("accept_after_release", 32'(acc_times[acc_times.size()-1]), 32'(rel_cyc + 1));

    // Back-to-back with in_valid and res_ready always high
    idx0 = acc_times.size();
    for (int i = 0; i < 4; i++) begin
      send_line(W'($urandom), 1'(i % 2), 1'b1, 1'b1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_period", 32'(acc_times[idx0+i+1] - acc_times[idx0+i]), 32'(W + SE + 2));
    end

    // Reset in the middle of a line
    tick();
    in_data  = 21'h1FFFFF;
    in_valid = 1'b1;
    tick();  // accept edge t, now t+1
    in_valid = 1'b0;
    repeat (9) tick();  // now t+10
    reset = 1'b1;
    tick();
    reset = 1'b0;
    line_m = '0;
    mc_m   = '0;
    chk("midrst_re_ic", 32'(re_ic), 32'(0));
    chk("midrst_re_i", 32'(re_i), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_match_count", 32'(match_count), 32'(0));
    rv_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) rv_seen++;
      tick();
    end
    chk("midrst_no_result", 32'(rv_seen), 32'(0));
    send_line(21'h0C0C0C, 1'b0, 1'b1, 1'b0);

    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
